opb_register_simulink2ppc_buf: RTL and testbench

OPB slave register block that carries a 32-bit word from the Simulink fabric to the PowerPC: the readback direction of the PPC-to-Simulink control registers. A user-side valid strobe captures `user_data_in` into a holding register. The PPC reads that word, a sticky new-data flag and a saturating overrun count over OPB. A small control word lets software freeze capture and clear the status. Everything runs on OPB_Clk; the user logic is already synchronous to OPB_Clk.

---
 rtl/opb_register_simulink2ppc_buf.sv | 113 +++++++++++
 tb/tb_opb_register_simulink2ppc_buf.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/opb_register_simulink2ppc_buf.sv
// OPB slave that hands a fabric-captured 32-bit word to the PowerPC, with a sticky
// new-data flag, a saturating overrun count and a freeze/clear control word.
module opb_register_simulink2ppc_buf #(
  parameter logic [31:0] C_BASEADDR   = 32'h0102D000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0102D0FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex6"
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst_n,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  input  logic [31:0] user_data_in,
  input  logic        user_data_valid,
  output logic        user_new_data
);

  localparam bit unused_params = (C_OPB_AWIDTH == 32) && (C_OPB_DWIDTH == 32) && (C_FAMILY != "");

  logic        unused_ok;
  logic        hit, ack_d, reg_sel, fire;
  logic [1:0]  word_idx;
  logic [31:0] rd_word;
  logic [31:0] data_q;
  logic        new_q, freeze_q;
  logic [15:0] ovr_q;
  logic        data_rd_p1, ctrl_wr_p1, frz_bit_p1, clr_bit_p1;
  logic        rd_clr, ctrl_wr, clr, cap;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign unused_ok  = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:29]};
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign hit      = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign ack_d    = hit && !Sl_xferAck;
  assign word_idx = OPB_ABus[28:29];
  // Offsets 0x10 and above must not alias onto the three real words.
  assign reg_sel  = (OPB_ABus[24:27] == 4'd0);

  always_comb begin
    rd_word = '0;
    if (reg_sel) begin
      case (word_idx)
        2'd0:    rd_word = data_q;
        2'd1:    rd_word = {ovr_q, 14'd0, freeze_q, new_q};
        2'd2:    rd_word = {31'd0, freeze_q};
        default: rd_word = '0;
      endcase
    end
  end

  // Stage p0 -> p1: register ack, read data and the decoded access for the ack cycle
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      Sl_xferAck <= 1'b0;
      Sl_DBus    <= '0;
      data_rd_p1 <= 1'b0;
      ctrl_wr_p1 <= 1'b0;
      frz_bit_p1 <= 1'b0;
      clr_bit_p1 <= 1'b0;
    end else begin
      Sl_xferAck <= ack_d;
      Sl_DBus    <= ack_d ? rd_word : '0;
      if (ack_d) begin
        data_rd_p1 <= OPB_RNW && reg_sel && (word_idx == 2'd0);
        ctrl_wr_p1 <= !OPB_RNW && reg_sel && (word_idx == 2'd2) && OPB_BE[3];
        frz_bit_p1 <= OPB_DBus[31];
        clr_bit_p1 <= OPB_DBus[30];
      end
    end
  end

  // Side effects land at the edge closing the ack cycle, only if select is still held
  assign fire    = Sl_xferAck && OPB_select;
  assign rd_clr  = fire && data_rd_p1;
  assign ctrl_wr = fire && ctrl_wr_p1;
  assign clr     = ctrl_wr && clr_bit_p1;
  assign cap     = user_data_valid && !freeze_q;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      data_q   <= '0;
      new_q    <= 1'b0;
      ovr_q    <= '0;
      freeze_q <= 1'b0;
    end else begin
      if (cap) data_q <= user_data_in;
      if (cap)                 new_q <= 1'b1;
      else if (clr || rd_clr)  new_q <= 1'b0;
      if (clr)                             ovr_q <= '0;
      else if (cap && new_q && !rd_clr)    ovr_q <= sat_inc(ovr_q);
      if (ctrl_wr) freeze_q <= frz_bit_p1;
    end
  end

  assign user_new_data = new_q;

endmodule

// File: tb/tb_opb_register_simulink2ppc_buf.sv
// Directed bench for opb_register_simulink2ppc_buf: vector table plus corner sequences.
module tb_opb_register_simulink2ppc_buf;

  localparam logic [31:0] BASE = 32'h0102D000;
  localparam int OP_RD = 0, OP_WR = 1, OP_ST = 2;

  typedef struct {
    int          op;
    logic [31:0] off;
    logic [31:0] dat;   // write data, strobe data, or expected read value
  } vec_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [0:31] abus = '0, dbus = '0;
  logic [0:3]  be = '0;
  logic        rnw = 1'b0, sel = 1'b0, seq = 1'b0;
  logic [0:31] sl_dbus;
  logic        ack, errack, retry, tout;
  logic [31:0] udata = '0;
  logic        uvalid = 1'b0;
  logic        unew;
  int          nchk = 0, nerr = 0;
  vec_t        tbl[$];

  opb_register_simulink2ppc_buf dut (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(sl_dbus),
    .Sl_xferAck(ack), .Sl_errAck(errack), .Sl_retry(retry), .Sl_toutSup(tout),
    .user_data_in(udata), .user_data_valid(uvalid), .user_new_data(unew)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] addr, input logic is_rd, input logic [31:0] wdata,
                      input logic stb, input logic [31:0] sdata, input string name,
                      output logic [31:0] rdata);
    int lat;
    lat = 0;
    rdata = '0;
    @(posedge clk); #1;
    abus = addr; rnw = is_rd; be = 4'hF; dbus = wdata; sel = 1'b1;
    while (lat < 4 && ack !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_lat"}, lat, 1);
    if (ack === 1'b1) begin
      rdata = sl_dbus;
      if (stb) begin udata = sdata; uvalid = 1'b1; end
      @(posedge clk); #1;
      check({name, "_ackw"}, {31'd0, ack}, 32'd0);
    end
    sel = 1'b0; uvalid = 1'b0;
  endtask

  task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string name);
    logic [31:0] r;
    xfer(BASE + off, 1'b1, 32'd0, 1'b0, 32'd0, name, r);
    check(name, r, exp);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d, input string name);
    logic [31:0] r;
    xfer(BASE + off, 1'b0, d, 1'b0, 32'd0, name, r);
  endtask

  task automatic strobe(input logic [31:0] d);
    @(posedge clk); #1;
    udata = d; uvalid = 1'b1;
    @(posedge clk); #1;
    uvalid = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] bad_addr [2];

    tbl.push_back('{OP_RD, 32'h00, 32'h00000000});
    tbl.push_back('{OP_RD, 32'h04, 32'h00000000});
    tbl.push_back('{OP_ST, 32'h00, 32'hDEADBEEF});
    tbl.push_back('{OP_RD, 32'h04, 32'h00000001});
    tbl.push_back('{OP_RD, 32'h00, 32'hDEADBEEF});
    tbl.push_back('{OP_RD, 32'h04, 32'h00000000});
    tbl.push_back('{OP_ST, 32'h00, 32'h00000001});
    tbl.push_back('{OP_ST, 32'h00, 32'h00000002});
    tbl.push_back('{OP_ST, 32'h00, 32'h00000003});
    tbl.push_back('{OP_RD, 32'h04, 32'h00020001});
    tbl.push_back('{OP_RD, 32'h00, 32'h00000003});
    tbl.push_back('{OP_WR, 32'h08, 32'h00000001});
    tbl.push_back('{OP_RD, 32'h08, 32'h00000001});
    tbl.push_back('{OP_RD, 32'h04, 32'h00020002});
    tbl.push_back('{OP_ST, 32'h00, 32'h12345678});
    tbl.push_back('{OP_RD, 32'h04, 32'h00020002});
    tbl.push_back('{OP_RD, 32'h00, 32'h00000003});
    tbl.push_back('{OP_WR, 32'h08, 32'h00000002});
    tbl.push_back('{OP_RD, 32'h04, 32'h00000000});
    tbl.push_back('{OP_RD, 32'h08, 32'h00000000});
    tbl.push_back('{OP_WR, 32'h00, 32'hFFFFFFFF});
    tbl.push_back('{OP_RD, 32'h00, 32'h00000003});
    tbl.push_back('{OP_WR, 32'h04, 32'hFFFFFFFF});
    tbl.push_back('{OP_RD, 32'h04, 32'h00000000});
    tbl.push_back('{OP_RD, 32'h10, 32'h00000000});
    tbl.push_back('{OP_RD, 32'hFC, 32'h00000000});
    tbl.push_back('{OP_WR, 32'hFC, 32'hFFFFFFFF});
    tbl.push_back('{OP_ST, 32'h00, 32'hA5A5A5A5});
    tbl.push_back('{OP_ST, 32'h00, 32'h5A5A5A5A});
    tbl.push_back('{OP_RD, 32'h04, 32'h00010001});
    tbl.push_back('{OP_WR, 32'h08, 32'h00000003});
    tbl.push_back('{OP_RD, 32'h04, 32'h00000002});
    tbl.push_back('{OP_RD, 32'h08, 32'h00000001});
    tbl.push_back('{OP_WR, 32'h08, 32'h00000000});
    tbl.push_back('{OP_RD, 32'h04, 32'h00000000});
    tbl.push_back('{OP_RD, 32'h00, 32'h5A5A5A5A});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dbus", sl_dbus, 32'd0);
    check("rst_new", {31'd0, unew}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      case (tbl[i].op)
        OP_RD:   rd(tbl[i].off, tbl[i].dat, $sformatf("vec%0d_rd%02h", i, tbl[i].off));
        OP_WR:   wr(tbl[i].off, tbl[i].dat, $sformatf("vec%0d_wr%02h", i, tbl[i].off));
        default: strobe(tbl[i].dat);
      endcase
    end

    // Overrun saturation: a long run of back-to-back strobes
    @(posedge clk); #1;
    udata = 32'h77777777; uvalid = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    uvalid = 1'b0;
    check("sat_new", {31'd0, unew}, 32'd1);
    rd(32'h04, 32'hFFFF0001, "sat_status");
    wr(32'h08, 32'h00000002, "sat_clr");
    rd(32'h04, 32'h00000000, "sat_after_clr");
    rd(32'h00, 32'h77777777, "sat_data");

    // Capture in the same cycle as a DATA-read ack
    strobe(32'h11111111);
    xfer(BASE, 1'b1, 32'd0, 1'b1, 32'h22222222, "simrd", r);
    check("simrd_old", r, 32'h11111111);
    rd(32'h04, 32'h00000001, "simrd_status");
    rd(32'h00, 32'h22222222, "simrd_data");

    // Capture in the same cycle as CLR
    strobe(32'h33333333);
    strobe(32'h44444444);
    rd(32'h04, 32'h00010001, "simclr_pre");
    xfer(BASE + 32'h08, 1'b0, 32'h00000002, 1'b1, 32'h55555555, "simclr", r);
    rd(32'h04, 32'h00000001, "simclr_status");
    rd(32'h00, 32'h55555555, "simclr_data");

    // Select held for six cycles: acks every other cycle
    @(posedge clk); #1;
    abus = BASE + 32'h04; rnw = 1'b1; sel = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("hold_ack%0d", i), {31'd0, ack}, (i % 2));
      if (ack !== 1'b1) check($sformatf("hold_dbus%0d", i), sl_dbus, 32'd0);
    end
    sel = 1'b0;

    // Outside the window: no ack, bus stays zero
    bad_addr[0] = BASE + 32'h100;
    bad_addr[1] = BASE - 32'h4;
    for (int a = 0; a < 2; a++) begin
      @(posedge clk); #1;
      abus = bad_addr[a]; rnw = 1'b1; sel = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        check($sformatf("oow%0d_ack%0d", a, c), {31'd0, ack}, 32'd0);
        check($sformatf("oow%0d_dbus%0d", a, c), sl_dbus, 32'd0);
      end
      sel = 1'b0;
    end

    // Aborted DATA read: ack still issues, NEW is not cleared
    strobe(32'h66666666);
    @(posedge clk); #1;
    abus = BASE; rnw = 1'b1; sel = 1'b1;
    @(posedge clk); #1;
    sel = 1'b0;
    check("abort_ack", {31'd0, ack}, 32'd1);
    check("abort_dbus", sl_dbus, 32'h66666666);
    @(posedge clk); #1;
    check("abort_new", {31'd0, unew}, 32'd1);
    rd(32'h04, 32'h00000001, "abort_status");

    // Reset in the middle of an ack
    @(posedge clk); #1;
    abus = BASE + 32'h04; rnw = 1'b1; sel = 1'b1;
    @(posedge clk); #1;
    check("midrst_ack_pre", {31'd0, ack}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_ack", {31'd0, ack}, 32'd0);
    check("midrst_dbus", sl_dbus, 32'd0);
    check("midrst_new", {31'd0, unew}, 32'd0);
    sel = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd(32'h04, 32'h00000000, "midrst_status");
    rd(32'h00, 32'h00000000, "midrst_data");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
